// File: rtl/bin_to_bcd_seq_if.sv
// Handshake bundle for the sequential binary-to-BCD converter.
// The master issues start/bin_in, and the slave (converter) returns status and the result.
interface bin_to_bcd_seq_if #(
   parameter int BIN_W  = 16,
   parameter int DIGITS = 8
) ();
   logic                  start;
   logic [BIN_W-1:0]      bin_in;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   bcd_out;
   logic                  overflow;

   modport master (
      output start, bin_in,
      input  busy, done, bcd_out, overflow
   );

   modport slave (
      input  start, bin_in,
      output busy, done, bcd_out, overflow
   );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Shift-and-add-3 binary-to-BCD converter that processes one input bit per clock.
// The result sits in a holding register and changes only when done pulses.
module bin_to_bcd_seq #(
   parameter int BIN_W  = 16,
   parameter int DIGITS = 8
) (
   input  logic              clk,
   input  logic              rst,
   bin_to_bcd_seq_if.slave   bus
);
   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

   state_t             state_q, state_d;
   logic [BIN_W-1:0]   shift_q, shift_d;
   logic [BCD_W-1:0]   scratch_q, scratch_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               sticky_q, sticky_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic               ovf_q, ovf_d;
   logic [BCD_W-1:0]   corrected;

   // Each digit is corrected independently, before the shift.
   always_comb begin
      corrected = scratch_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (scratch_q[4*i +: 4] >= 4'd5) begin
            corrected[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      scratch_d = scratch_q;
      cnt_d     = cnt_q;
      sticky_d  = sticky_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      bcd_d     = bcd_q;
      ovf_d     = ovf_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               shift_d   = bus.bin_in;
               scratch_d = '0;
               sticky_d  = 1'b0;
               cnt_d     = CNT_W'(BIN_W);
               busy_d    = 1'b1;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            // A set top bit would carry into a digit that does not exist, so record overflow.
            if (corrected[BCD_W-1]) begin
               sticky_d = 1'b1;
            end
            scratch_d = {corrected[BCD_W-2:0], shift_q[BIN_W-1]};
            shift_d   = shift_q << 1;
            cnt_d     = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = FINISH;
            end
         end
         FINISH: begin
            bcd_d   = scratch_q;
            ovf_d   = sticky_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         scratch_q <= '0;
         cnt_q     <= '0;
         sticky_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         bcd_q     <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         scratch_q <= scratch_d;
         cnt_q     <= cnt_d;
         sticky_q  <= sticky_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         bcd_q     <= bcd_d;
         ovf_q     <= ovf_d;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.bcd_out  = bcd_q;
   assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq.
// dut_a uses the default configuration (8 digits), and dut_b uses 4 digits to exercise overflow.
module tb_bin_to_bcd_seq;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   bin_to_bcd_seq_if #(.BIN_W(16), .DIGITS(8)) if_a ();
   bin_to_bcd_seq_if #(.BIN_W(16), .DIGITS(4)) if_b ();

   bin_to_bcd_seq #(.BIN_W(16), .DIGITS(8)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
   bin_to_bcd_seq #(.BIN_W(16), .DIGITS(4)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

   typedef struct packed {
      logic [31:0] bcd;
      logic        ovf;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   exp_t e_a, e_b;
   int   checks = 0;
   int   errors = 0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   function automatic logic getDone(input bit sel);
      return sel ? if_b.done : if_a.done;
   endfunction

   function automatic logic getBusy(input bit sel);
      return sel ? if_b.busy : if_a.busy;
   endfunction

   task automatic setIn(input bit sel, input logic s, input logic [15:0] v);
      if (sel) begin
         if_b.start  = s;
         if_b.bin_in = v;
      end else begin
         if_a.start  = s;
         if_a.bin_in = v;
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && if_a.done) begin
         if (q_a.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_done_a: got done with bcd %0h, expected no done", if_a.bcd_out);
         end else begin
            e_a = q_a.pop_front();
            checkOutput("bcd_a", if_a.bcd_out, e_a.bcd);
            checkOutput("ovf_a", 32'(if_a.overflow), 32'(e_a.ovf));
         end
      end
      if (!rst && if_b.done) begin
         if (q_b.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_done_b: got done with bcd %0h, expected no done", if_b.bcd_out);
         end else begin
            e_b = q_b.pop_front();
            checkOutput("bcd_b", {16'h0, if_b.bcd_out}, e_b.bcd);
            checkOutput("ovf_b", 32'(if_b.overflow), 32'(e_b.ovf));
         end
      end
   end

   // Waits from just after an accepting edge until done, counting edges and busy samples.
   task automatic waitDone(input bit sel, output int edges, output int busy_cnt);
      edges    = 0;
      busy_cnt = 0;
      do begin
         @(posedge clk);
         #1;
         edges++;
         if (getBusy(sel)) busy_cnt++;
      end while (!getDone(sel) && edges < 40);
      if (!getDone(sel)) begin
         checks++;
         errors++;
         $display("[TB] FAIL done_timeout: got no done after %0d edges, expected done", edges);
      end
   endtask

   task automatic applyStimulus(input bit sel, input logic [15:0] value, input logic [31:0] exp_bcd,
                                input logic exp_ovf, input string name);
      exp_t e;
      int   edges, bc;
      e.bcd = exp_bcd;
      e.ovf = exp_ovf;
      if (sel) q_b.push_back(e); else q_a.push_back(e);
      @(negedge clk);
      setIn(sel, 1'b1, value);
      @(posedge clk);
      #1;
      setIn(sel, 1'b0, value);
      checkOutput({name, "_busy_on_accept"}, 32'(getBusy(sel)), 32'd1);
      waitDone(sel, edges, bc);
      checkOutput({name, "_latency"}, 32'(edges), 32'd17);
      checkOutput({name, "_busy_cycles"}, 32'(bc + 1), 32'd17);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int   edges, bc, dn;
      exp_t e;

      // Reset held with start asserted: everything must stay cleared.
      rst = 1'b1;
      setIn(0, 1'b1, 16'hFFFF);
      setIn(1, 1'b1, 16'hFFFF);
      @(posedge clk);
      #1;
      checkOutput("rst_busy", 32'(if_a.busy), 32'd0);
      checkOutput("rst_done", 32'(if_a.done), 32'd0);
      checkOutput("rst_ovf", 32'(if_a.overflow), 32'd0);
      checkOutput("rst_bcd", if_a.bcd_out, 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      setIn(0, 1'b0, 16'h0);
      setIn(1, 1'b0, 16'h0);
      @(posedge clk);
      #1;
      checkOutput("post_rst_busy", 32'(if_a.busy), 32'd0);
      checkOutput("post_rst_done", 32'(if_a.done), 32'd0);
      checkOutput("post_rst_bcd", if_a.bcd_out, 32'h0);
      checkOutput("post_rst_ovf_b", 32'(if_b.overflow), 32'd0);

      applyStimulus(0, 16'd0,     32'h00000000, 1'b0, "conv0");
      applyStimulus(0, 16'd1234,  32'h00001234, 1'b0, "conv1234");
      applyStimulus(0, 16'd65535, 32'h00065535, 1'b0, "conv65535");

      // A start issued while busy must be ignored, and a start in the done cycle must be accepted.
      e.bcd = 32'h00004321;
      e.ovf = 1'b0;
      q_a.push_back(e);
      @(negedge clk);
      setIn(0, 1'b1, 16'd4321);
      @(posedge clk);
      #1;
      setIn(0, 1'b0, 16'h1111);
      fork
         waitDone(0, edges, bc);
         begin
            repeat (5) @(negedge clk);
            setIn(0, 1'b1, 16'd9999);
            @(negedge clk);
            setIn(0, 1'b0, 16'h2222);
         end
      join
      checkOutput("busy_ignore_latency", 32'(edges), 32'd17);
      e.bcd = 32'h00000007;
      q_a.push_back(e);
      setIn(0, 1'b1, 16'd7);
      @(posedge clk);
      #1;
      setIn(0, 1'b0, 16'h0);
      waitDone(0, edges, bc);
      checkOutput("b2b_gap", 32'(edges + 1), 32'd18);

      // The result must hold while bin_in wanders and start stays low.
      applyStimulus(0, 16'd250, 32'h00000250, 1'b0, "conv250");
      @(posedge clk);
      repeat (100) begin
         @(negedge clk);
         if_a.bin_in = 16'($urandom);
         checkOutput("hold_bcd", if_a.bcd_out, 32'h00000250);
         checkOutput("hold_done", 32'(if_a.done), 32'd0);
      end

      applyStimulus(1, 16'd12345, 32'h00002345, 1'b1, "ovf12345");
      applyStimulus(1, 16'd9999,  32'h00009999, 1'b0, "ovf9999");

      // Reset around the eighth shift aborts the conversion with no done pulse.
      @(negedge clk);
      setIn(0, 1'b1, 16'd500);
      @(posedge clk);
      #1;
      setIn(0, 1'b0, 16'd500);
      repeat (7) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("abort_busy", 32'(if_a.busy), 32'd0);
      checkOutput("abort_done", 32'(if_a.done), 32'd0);
      checkOutput("abort_bcd", if_a.bcd_out, 32'h0);
      checkOutput("abort_ovf", 32'(if_a.overflow), 32'd0);
      checkOutput("abort_bcd_b", {16'h0, if_b.bcd_out}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      dn = 0;
      repeat (30) begin
         @(posedge clk);
         #1;
         if (if_a.done) dn++;
      end
      checkOutput("abort_no_done", 32'(dn), 32'd0);
      applyStimulus(0, 16'd42, 32'h00000042, 1'b0, "conv42");

      repeat (3) @(negedge clk);
      checkOutput("scoreboard_a_drained", 32'(q_a.size()), 32'd0);
      checkOutput("scoreboard_b_drained", 32'(q_b.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) that feeds the 8-digit seven-segment multiplexer. It accepts an unsigned binary value, such as a scaled temperature reading, through a start/busy/done handshake. It presents the result as packed BCD, with digit 0 in bits [3:0], on a registered output that holds steady between conversions so the display never shows intermediate values.

## Interface
- `BIN_W`, default 16: width of the binary input; must be ≥ 2.
- `DIGITS`, default 8: number of BCD digits; `bcd_out` is 4·DIGITS bits wide.

Ports, clock and reset first:
- `clk`: input, 1 bit. Single clock for the whole block.
- `rst`: input, 1 bit. Reset is synchronous and active-high.
- `start`: input, 1 bit. Request a conversion of `bin_in`; sampled only in IDLE.
- `bin_in`: input, BIN_W bits. Unsigned value; captured on the accepting edge only.
- `busy`: output, 1 bit. Registered; high while a conversion is in progress.
- `done`: output, 1 bit. Registered; one-cycle pulse when `bcd_out` and `overflow` update.
- `bcd_out`: output, 4·DIGITS bits. Packed BCD result; digit i is at [4i+3:4i]; held until the next `done`.
- `overflow`: output, 1 bit. High if the last converted value exceeded 10^DIGITS − 1; held until the next `done`.

## Operation
- **State machine: IDLE, SHIFT, FINISH.**
- **IDLE**
  - If `start` = 1: capture `bin_in` into the shift register, clear the scratch BCD register and the sticky overflow flag, load the bit counter with BIN_W, set `busy` = 1, and go to SHIFT.
  - Otherwise stay in IDLE.
- **SHIFT (each cycle)**
  - For every scratch digit ≥ 5, add 3 to it.
  - Shift the concatenation {scratch, bin} left by one bit; the bin MSB enters scratch bit 0.
  - If the corrected top digit had bit 3 set before the shift, set the sticky overflow flag. That bit is discarded.
  - Decrement the counter. When the counter reaches 0 after this shift, go to FINISH.
- **FINISH**
  - `bcd_out` ← scratch, `overflow` ← sticky flag, `done` ← 1, `busy` ← 0. Go to IDLE.
- **Outputs**
  - `done` is high exactly one cycle per conversion.
  - `bcd_out` and `overflow` change only on the edge that raises `done`, or on reset.
- **Arithmetic**
  - The add-3 correction is applied per 4-bit digit, independently, on the pre-shift value.
  - Digits above the most significant non-zero digit read 0; there is no leading-zero blanking.
  - On overflow, `bcd_out` holds value mod 10^DIGITS: the low digits stay correct.
- **Boundary conditions**
  - `start` while `busy` = 1 is ignored; there is no queueing, and `bin_in` is not re-sampled.
  - `start` during the cycle in which `done` = 1 is accepted, since the block is in IDLE. This gives back-to-back throughput of one conversion every BIN_W + 2 cycles.
  - `bin_in` changes after the accepting edge have no effect on the conversion in progress.
  - `rst` mid-conversion aborts it: state goes to IDLE and all outputs are cleared.
  - `rst` and `start` in the same cycle: reset wins and the start is dropped.

## Timing
- **Reset values:** `busy` = 0, `done` = 0, `bcd_out` = 0, `overflow` = 0, state = IDLE. Internal shift, scratch and counter registers are cleared.
- **Start accepted at edge k:**
  - `busy` = 1 from edge k.
  - Shifts occur at edges k+1 through k+BIN_W.
  - FINISH completes at edge k+BIN_W+1: `done` = 1, `busy` = 0, and outputs update.
- **Latency** from the accepting edge to `done` is BIN_W + 1 edges; this is 17 with the defaults.
- `done` falls at edge k+BIN_W+2, unless reset occurs first.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset:** hold `rst` for 2 cycles with `start` = 1 and `bin_in` = 16'hFFFF → `busy`, `done`, `overflow` = 0 and `bcd_out` = 32'h0, both during reset and on the first cycle after it.
- **Basic values (defaults):** 0 → 32'h00000000; 1234 → 32'h00001234; 65535 → 32'h00065535. In each case `done` rises exactly 17 edges after the accepting edge, `busy` is high for 17 cycles, and `overflow` = 0.
- **Busy and back-to-back:**
  - Convert 4321, pulse `start` with `bin_in` = 9999 mid-conversion → result is 32'h00004321, and there is no second `done`.
  - Then assert `start` with 7 in the `done` cycle → next result is 32'h00000007, 18 cycles after the previous `done`.
- **Output hold:** after converting 250, toggle `bin_in` randomly for 100 cycles with `start` = 0 → `bcd_out` stays 32'h00000250 and `done` stays 0.
- **Overflow (DIGITS = 4, BIN_W = 16):**
  - 12345 → `bcd_out` = 16'h2345, `overflow` = 1.
  - Following conversion of 9999 → 16'h9999, `overflow` = 0.
- **Reset mid-operation:** start converting 500, assert `rst` at shift 8 → all outputs 0, no `done` pulse. A new start with 42 then yields 32'h00000042 after 17 edges.
